fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares one async-FIFO write side among NREQ requesters. It grants the write port in bursts of up to MAX_BURST words and drives winc/wdata into the FIFO's write domain. It uses the write-side wfull and walmost_full flags for backpressure and burst truncation. It sits entirely in the write clock domain, directly in front of the FIFO write pointer/full logic.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, data width per word
MAX_BURST, 4, maximum words transferred per grant (1..16)

Ports:
clk  input  1  write-domain clock
wrst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester word valid
req_data  input  NREQ*DW  per-requester data; requester i occupies bits [i*DW +: DW]
req_ready  output  NREQ  per-requester accept; a word transfers when valid&ready
wfull  input  1  FIFO full flag; may assert asynchronously to clk
walmost_full  input  1  FIFO almost-full flag
winc  output  1  FIFO write enable
wdata  output  DW  FIFO write data
grant_id  output  clog2(NREQ)  current/last granted requester
busy  output  1  high while in BURST

Behaviour:
- Reset is asynchronous and active-low on wrst_n. Reset values: state=IDLE, grant_id=0, rr_ptr=NREQ-1 (requester 0 has first priority), burst_cnt=0, busy=0. winc=0 and req_ready=0 all take effect immediately, with no clock edge needed.
- States: IDLE, BURST.
- IDLE:
  - req_ready=0, winc=0.
  - If any req_valid=1 and wfull=0, pick the first valid requester searching from rr_ptr+1 upward, modulo NREQ.
  - On the next edge: grant_id<=pick, rr_ptr<=pick, burst_cnt<=0, state<=BURST.
  - If no requester is valid, or wfull=1, stay in IDLE.
- BURST (g=grant_id):
  - req_ready[g] = ~wfull (combinational). All other req_ready bits are 0.
  - xfer = req_valid[g] & ~wfull. winc = xfer. wdata = req_data[g] (combinational mux, only meaningful when winc=1).
  - winc must never be 1 while wfull=1, including in the same cycle wfull asserts.
  - On xfer: burst_cnt<=burst_cnt+1.
  - Return to IDLE at the edge following a cycle where any of these holds:
    - (a) xfer and burst_cnt==MAX_BURST-1
    - (b) xfer and walmost_full=1 (at most one word per grant while almost full)
    - (c) req_valid[g]=0
  - wfull=1 with req_valid[g]=1: hold BURST, no transfer, burst_cnt unchanged. The burst resumes when wfull falls.
- Latency and throughput:
  - A request sampled in IDLE at edge t gives its first possible winc in cycle t+1.
  - Exactly one IDLE bubble cycle separates consecutive bursts.
  - Peak throughput is MAX_BURST words per MAX_BURST+1 cycles.
- Fairness: the last-granted requester has the lowest priority at the next arbitration. A requester that drops valid loses its grant and is not re-granted out of turn.
- busy = (state==BURST). grant_id holds its last value in IDLE.
- Requester obligation (checked by assertion, not by RTL): once valid, req_data holds until the word transfers or valid drops.
- Reset mid-burst: the burst is abandoned and no partial count is retained. After reset release, arbitration restarts from requester 0.
- burst_cnt width is clog2(MAX_BURST+1). It never exceeds MAX_BURST-1 at a transfer.

Test Plan:
1. Reset, then requester 0 holds valid with data 0x10,0x11,... and flags low -> BURST entered 1 cycle after valid; winc=1 for 4 consecutive cycles writing 0x10-0x13; one IDLE cycle; re-grant to 0; next burst writes 0x14-0x17.
2. All four requesters continuously valid -> grant_id sequence 0,1,2,3,0,1; each burst exactly 4 winc pulses; busy low exactly 1 cycle between bursts.
3. Requester 1 granted; wfull asserts mid-cycle after 2 words, held 5 cycles -> winc=0 and req_ready[1]=0 from the same cycle; burst resumes; total of 4 words for the grant, no duplicates or losses.
4. walmost_full held high, requesters 0 and 2 valid -> each grant writes 1 word; order 0,2,0,2; winc duty 1 in 2 cycles.
5. Requester 3 granted; it drops valid after 1 word while requester 0 is valid -> BURST exits the next edge; requester 0 granted after the IDLE cycle; burst_cnt restarts at 0.
6. wrst_n pulsed low mid-burst between edges -> winc, req_ready and busy go 0 immediately; after release with all requesters valid, the first grant is requester 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side handshake bundle: requester valid/ready/data, FIFO write port and flags, arbiter status.
// The master modport is the arbiter; the slave modport is the requester/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               wfull;
  logic               walmost_full;
  logic               winc;
  logic [DW-1:0]      wdata;
  logic [GW-1:0]      grant_id;
  logic               busy;

  modport master (
    input  req_valid, req_data, wfull, walmost_full,
    output req_ready, winc, wdata, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, wfull, walmost_full,
    input  req_ready, winc, wdata, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port; first winc one cycle after a grant.
// Backpressure: wfull gates winc/req_ready combinationally; walmost_full limits a grant to one word.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              wrst_n,
  fifo_wr_arbiter_if.master bus
);
  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t          r_state;
  logic [GW-1:0]   r_grant_id;
  logic [GW-1:0]   r_rr_ptr;
  logic [CW-1:0]   r_burst_cnt;
  logic            r_busy;

  logic            w_any;
  logic [GW-1:0]   w_pick;
  logic [GW-1:0]   w_idx;
  logic            w_gvalid;
  logic [DW-1:0]   w_gdata;
  logic            w_xfer;
  logic            w_last;

  // Descending scan so the nearest requester after rr_ptr is the final assignment.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = GW'((int'(r_rr_ptr) + k) % NREQ);
      if (bus.req_valid[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  always_comb begin
    w_gvalid = 1'b0;
    w_gdata  = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (r_grant_id == GW'(j)) begin
        w_gvalid = bus.req_valid[j];
        w_gdata  = bus.req_data[j*DW +: DW];
      end
    end
  end

  // wfull is used raw so a late-asserting full blocks the write in the same cycle.
  assign w_xfer = (r_state == S_BURST) && w_gvalid && !bus.wfull;
  assign w_last = !w_gvalid ||
                  (w_xfer && ((r_burst_cnt == CW'(MAX_BURST - 1)) || bus.walmost_full));

  assign bus.req_ready = ((r_state == S_BURST) && !bus.wfull) ? (NREQ'(1) << r_grant_id) : '0;
  assign bus.winc      = w_xfer;
  assign bus.wdata     = w_gdata;
  assign bus.grant_id  = r_grant_id;
  assign bus.busy      = r_busy;

  always_ff @(posedge clk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state     <= S_IDLE;
      r_grant_id  <= '0;
      r_rr_ptr    <= GW'(NREQ - 1);
      r_burst_cnt <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any && !bus.wfull) begin
            r_grant_id  <= w_pick;
            r_rr_ptr    <= w_pick;
            r_burst_cnt <= '0;
            r_state     <= S_BURST;
            r_busy      <= 1'b1;
          end
        end
        S_BURST: begin
          if (w_xfer) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
          end
          if (w_last) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against an owner/word-count reference model.
module tb_fifo_wr_arbiter;
  localparam int NREQ      = 4;
  localparam int DW        = 8;
  localparam int MAX_BURST = 4;

  logic clk    = 1'b0;
  logic wrst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk    (clk),
    .wrst_n (wrst_n),
    .bus    (bus.master)
  );

  int   n_chk = 0;
  int   n_err = 0;
  int   owner;          // requester holding the port, -1 when idle
  int   last_gnt;       // lowest priority at next arbitration
  int   egid;
  int   words;
  int   nsent [NREQ];
  logic prev_busy;
  int   wlog[$];
  int   glog[$];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_hold
    assert property (@(posedge clk) disable iff (!wrst_n)
      (bus.req_valid[gi] && !bus.req_ready[gi]) |=>
      (!bus.req_valid[gi] || $stable(bus.req_data[gi*DW +: DW])))
      else $error("requester %0d changed data while waiting", gi);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] dat(input int i, input int n);
    return DW'(16 + 64 * i + n);
  endfunction

  task automatic drive_data();
    for (int i = 0; i < NREQ; i++) bus.req_data[i*DW +: DW] = dat(i, nsent[i]);
  endtask

  // Evaluate one cycle of the reference model against the DUT outputs, then advance it.
  task automatic step();
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] er;
    logic            ew;
    v  = bus.req_valid;
    er = '0;
    ew = 1'b0;
    if (owner >= 0) begin
      ew = v[owner] && !bus.wfull;
      if (!bus.wfull) er[owner] = 1'b1;
    end
    chk("busy",  bus.busy,      32'(owner >= 0));
    chk("winc",  bus.winc,      32'(ew));
    chk("ready", bus.req_ready, 32'(er));
    chk("gid",   bus.grant_id,  32'(egid));
    if (ew) begin
      chk("wdata", bus.wdata, 32'(dat(owner, nsent[owner])));
      wlog.push_back(int'(bus.wdata));
    end
    if (bus.busy && !prev_busy) glog.push_back(int'(bus.grant_id));
    prev_busy = bus.busy;

    if (owner >= 0) begin
      if (ew) begin
        nsent[owner]++;
        words++;
      end
      if (!v[owner] || (ew && (words == MAX_BURST || bus.walmost_full))) owner = -1;
    end else if (v != '0 && !bus.wfull) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (owner < 0 && v[(last_gnt + k) % NREQ]) owner = (last_gnt + k) % NREQ;
      end
      last_gnt = owner;
      egid     = owner;
      words    = 0;
    end
  endtask

  task automatic cycle(input logic [NREQ-1:0] v, input logic wf, input logic waf);
    @(posedge clk);
    #2;
    bus.req_valid    = v;
    bus.walmost_full = waf;
    drive_data();
    #3 bus.wfull = wf;
    #3 step();
  endtask

  // Reset asserted between edges; v_after is presented while reset is held.
  task automatic do_reset(input logic [NREQ-1:0] v_after);
    @(posedge clk);
    #3 wrst_n = 1'b0;
    #1;
    chk("rst_winc",  bus.winc,      32'd0);
    chk("rst_ready", bus.req_ready, 32'd0);
    chk("rst_busy",  bus.busy,      32'd0);
    chk("rst_gid",   bus.grant_id,  32'd0);
    owner     = -1;
    last_gnt  = NREQ - 1;
    egid      = 0;
    words     = 0;
    prev_busy = 1'b0;
    for (int i = 0; i < NREQ; i++) nsent[i] = 0;
    wlog.delete();
    glog.delete();
    bus.req_valid    = v_after;
    bus.wfull        = 1'b0;
    bus.walmost_full = 1'b0;
    drive_data();
    @(posedge clk);
    #3 wrst_n = 1'b1;
    #5 step();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NREQ-1:0] rv;
    bus.req_valid    = '0;
    bus.req_data     = '0;
    bus.wfull        = 1'b0;
    bus.walmost_full = 1'b0;

    // Single requester: two back-to-back bursts separated by one idle cycle.
    do_reset(4'b0001);
    for (int c = 0; c < 9; c++) cycle(4'b0001, 1'b0, 1'b0);
    chk("t1_nwords", wlog.size(), 8);
    for (int i = 0; i < 8 && i < wlog.size(); i++) chk("t1_word", wlog[i], 16 + i);
    chk("t1_ngrants", glog.size(), 2);

    // All requesters valid: rotation 0,1,2,3,0,1.
    do_reset(4'b1111);
    for (int c = 0; c < 30; c++) cycle(4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 6 && i < glog.size(); i++) chk("t2_order", glog[i], i % NREQ);
    chk("t2_nwords", wlog.size(), 24);

    // wfull stall mid-burst on requester 1.
    do_reset(4'b0010);
    for (int c = 0; c < 2; c++) cycle(4'b0010, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) cycle(4'b0010, 1'b1, 1'b0);
    for (int c = 0; c < 2; c++) cycle(4'b0010, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);
    chk("t3_nwords", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) chk("t3_word", wlog[i], 80 + i);
    chk("t3_ngrants", glog.size(), 1);

    // Almost-full: one word per grant, alternating 0 and 2.
    do_reset(4'b0101);
    for (int c = 0; c < 7; c++) cycle(4'b0101, 1'b0, 1'b1);
    chk("t4_nwords", wlog.size(), 4);
    chk("t4_ngrants", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++) chk("t4_order", glog[i], (i % 2) * 2);

    // Requester 3 drops valid after one word; requester 0 takes a full burst.
    do_reset(4'b1000);
    cycle(4'b1000, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) cycle(4'b0001, 1'b0, 1'b0);
    chk("t5_nwords", wlog.size(), 5);
    if (wlog.size() >= 2) begin
      chk("t5_first", wlog[0], 208);
      chk("t5_req0",  wlog[1], 16);
    end
    if (glog.size() >= 2) begin
      chk("t5_g0", glog[0], 3);
      chk("t5_g1", glog[1], 0);
    end

    // Reset in the middle of requester 1's burst restarts arbitration at requester 0.
    do_reset(4'b1110);
    for (int c = 0; c < 2; c++) cycle(4'b1110, 1'b0, 1'b0);
    chk("t6_winc_pre", bus.winc, 32'd1);
    do_reset(4'b1111);
    for (int c = 0; c < 2; c++) cycle(4'b1111, 1'b0, 1'b0);
    chk("t6_ngrants", glog.size(), 1);
    if (glog.size() >= 1) chk("t6_first", glog[0], 0);

    // Randomized traffic with sticky valids and sporadic full/almost-full.
    rv = '0;
    do_reset(rv);
    for (int c = 0; c < 1600; c++) begin
      for (int i = 0; i < NREQ; i++) if ($urandom_range(0, 3) == 0) rv[i] = ~rv[i];
      cycle(rv, ($urandom_range(0, 6) == 0), ($urandom_range(0, 4) == 0));
      if (c == 800) do_reset(rv);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
